// File: rtl/branch_predictor.sv
// Purpose: direct-mapped BTB with 2-bit saturating direction counters, mispredict detection and perf counters.
// Latency: lookup and mispredict/redirect are combinational; table and counter updates take effect next cycle.
// Backpressure: none; if_valid/upd_valid qualify each cycle and the block accepts every request.
module branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Table state: valid and direction counters are reset, tag/target are only meaningful when valid.
    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Address split; pc[1:0] never participates in indexing or tagging.
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             unused_pc_bits;

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    logic       lk_hit;
    logic       up_hit;
    logic [1:0] up_ctr_d;

    // Fetch-side lookup: reads the current (pre-update) table contents.
    always_comb begin
        lk_hit      = if_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? target_q[lk_idx] : (if_pc + XLEN'(4));
    end

    // Resolution side: mispredict on wrong direction, or on taken-taken with a stale target.
    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : (upd_pc + XLEN'(4));
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr_d    = ctr_q[up_idx];
        if (upd_taken) begin
            if (ctr_q[up_idx] != 2'b11) up_ctr_d = ctr_q[up_idx] + 2'd1;
        end else begin
            if (ctr_q[up_idx] != 2'b00) up_ctr_d = ctr_q[up_idx] - 2'd1;
        end
    end

    // Valid bits and direction counters: reset to invalid/weak-not-taken, train on hits, allocate on taken misses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_d;
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target payload: any taken update (hit or allocate) records the latest target; a hit rewrites the same tag.
    always_ff @(posedge clk) begin
        if (reset && upd_valid && upd_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
        end
    end

    // Saturating next values for the performance counters.
    always_comb begin
        lookup_cnt_d  = lookup_cnt_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (if_valid && (lookup_cnt_q != {CNT_W{1'b1}}))
            lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
        if (upd_valid && (branch_cnt_q != {CNT_W{1'b1}}))
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}}))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lookup_cnt_q  <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            lookup_cnt_q  <= lookup_cnt_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign lookup_cnt  = lookup_cnt_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [31:0] lookup_cnt, branch_cnt, mispred_cnt;

    logic        pred_taken4, mispredict4;
    logic [63:0] pred_target4, redirect_pc4;
    logic [3:0]  lookup_cnt4, branch_cnt4, mispred_cnt4;

    int checks   = 0;
    int failures = 0;

    branch_predictor #(.XLEN(64), .ENTRIES(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .lookup_cnt(lookup_cnt), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_predictor #(.XLEN(64), .ENTRIES(16), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken4), .pred_target(pred_target4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict4), .redirect_pc(redirect_pc4),
        .lookup_cnt(lookup_cnt4), .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move 1 time unit past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [63:0] pc, input logic tk,
                           input logic [63:0] tgt, input logic ptk, input logic [63:0] ptgt);
        upd_valid = v; upd_pc = pc; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic set_lk(input logic v, input logic [63:0] pc);
        if_valid = v; if_pc = pc;
    endtask

    initial begin
        reset = 1'b0;
        set_lk(1'b0, 64'h40);
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        step(); step();
        reset = 1'b1;
        #1;

        // Post-reset state
        chk("rst_lookup_cnt", 64'(lookup_cnt), 64'd0);
        chk("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        chk("rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        chk("rst_pred_taken", 64'(pred_taken), 64'd0);
        chk("rst_pred_target", pred_target, 64'h44);
        chk("rst_mispredict", 64'(mispredict), 64'd0);

        // Cold lookup
        set_lk(1'b1, 64'h40); #1;
        chk("cold_pred_taken", 64'(pred_taken), 64'd0);
        chk("cold_pred_target", pred_target, 64'h44);
        step();
        chk("cold_lookup_cnt", 64'(lookup_cnt), 64'd1);
        chk("cold_lookup_cnt4", 64'(lookup_cnt4), 64'd1);

        // Same-cycle lookup + allocate of 0x40: lookup sees the old (empty) entry
        set_upd(1'b1, 64'h40, 1'b1, 64'h100, 1'b0, 64'h0); #1;
        chk("rbw_pred_taken", 64'(pred_taken), 64'd0);
        chk("alloc_mispredict", 64'(mispredict), 64'd1);
        chk("alloc_redirect", redirect_pc, 64'h100);
        step();
        chk("alloc_lookup_cnt", 64'(lookup_cnt), 64'd2);
        chk("alloc_branch_cnt", 64'(branch_cnt), 64'd1);
        chk("alloc_mispred_cnt", 64'(mispred_cnt), 64'd1);

        // Hit after allocate (ctr = 10)
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0); #1;
        chk("hit_pred_taken", 64'(pred_taken), 64'd1);
        chk("hit_pred_target", pred_target, 64'h100);
        step();

        // Not-taken update: ctr 10 -> 01; if_valid low forces fall-through
        set_lk(1'b0, 64'h40);
        set_upd(1'b1, 64'h40, 1'b0, 64'h0, 1'b1, 64'h100); #1;
        chk("nt_mispredict", 64'(mispredict), 64'd1);
        chk("nt_redirect", redirect_pc, 64'h44);
        chk("ifinv_pred_taken", 64'(pred_taken), 64'd0);
        chk("ifinv_pred_target", pred_target, 64'h44);
        step();
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        set_lk(1'b1, 64'h40); #1;
        chk("weak_nt_pred_taken", 64'(pred_taken), 64'd0);
        chk("weak_nt_pred_target", pred_target, 64'h44);
        step();
        chk("hyst_lookup_cnt", 64'(lookup_cnt), 64'd4);

        // Three taken updates: 01 -> 10 -> 11 -> 11
        set_lk(1'b0, 64'h40);
        set_upd(1'b1, 64'h40, 1'b1, 64'h100, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) step();
        chk("t3_branch_cnt", 64'(branch_cnt), 64'd5);
        chk("t3_mispred_cnt", 64'(mispred_cnt), 64'd5);

        // One not-taken: 11 -> 10, still predicts taken next cycle
        set_upd(1'b1, 64'h40, 1'b0, 64'h0, 1'b1, 64'h100);
        step();
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        set_lk(1'b1, 64'h40); #1;
        chk("strong_pred_taken", 64'(pred_taken), 64'd1);
        chk("strong_pred_target", pred_target, 64'h100);
        step();

        // Correct taken prediction: no mispredict (ctr 10 -> 11)
        set_lk(1'b0, 64'h40);
        set_upd(1'b1, 64'h40, 1'b1, 64'h100, 1'b1, 64'h100); #1;
        chk("ok_mispredict", 64'(mispredict), 64'd0);
        chk("ok_redirect", redirect_pc, 64'h100);
        step();
        chk("ok_mispred_cnt", 64'(mispred_cnt), 64'd6);

        // Wrong target
        set_upd(1'b1, 64'h40, 1'b1, 64'h200, 1'b1, 64'h100); #1;
        chk("wt_mispredict", 64'(mispredict), 64'd1);
        chk("wt_redirect", redirect_pc, 64'h200);
        step();
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        set_lk(1'b1, 64'h40); #1;
        chk("wt_pred_taken", 64'(pred_taken), 64'd1);
        chk("wt_pred_target", pred_target, 64'h200);
        step();
        chk("wt_branch_cnt", 64'(branch_cnt), 64'd8);
        chk("wt_mispred_cnt", 64'(mispred_cnt), 64'd7);

        // Alias at 0x80 (same index 0, different tag)
        set_lk(1'b1, 64'h80); #1;
        chk("alias_pred_taken", 64'(pred_taken), 64'd0);
        chk("alias_pred_target", pred_target, 64'h84);
        step();
        set_lk(1'b0, 64'h80);
        set_upd(1'b1, 64'h80, 1'b1, 64'h300, 1'b0, 64'h0);
        step();
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        set_lk(1'b1, 64'h40); #1;
        chk("evict_old_pred_taken", 64'(pred_taken), 64'd0);
        chk("evict_old_pred_target", pred_target, 64'h44);
        step();
        set_lk(1'b1, 64'h80); #1;
        chk("evict_new_pred_taken", 64'(pred_taken), 64'd1);
        chk("evict_new_pred_target", pred_target, 64'h300);
        step();
        chk("evict_lookup_cnt", 64'(lookup_cnt), 64'd9);

        // Not-taken miss at 0x48: no allocation
        set_lk(1'b0, 64'h48);
        set_upd(1'b1, 64'h48, 1'b0, 64'h0, 1'b0, 64'h0); #1;
        chk("ntmiss_mispredict", 64'(mispredict), 64'd0);
        chk("ntmiss_redirect", redirect_pc, 64'h4C);
        step();
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        set_lk(1'b1, 64'h48); #1;
        chk("ntmiss_pred_taken", 64'(pred_taken), 64'd0);
        chk("ntmiss_pred_target", pred_target, 64'h4C);
        step();
        chk("ntmiss_branch_cnt", 64'(branch_cnt), 64'd10);

        // +4 wrap on both adders
        set_lk(1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        set_upd(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0, 64'h0); #1;
        chk("wrap_pred_target", pred_target, 64'h0);
        chk("wrap_redirect", redirect_pc, 64'h0);

        // Reset mid-operation with a simultaneous taken update
        reset = 1'b0;
        set_lk(1'b1, 64'h80);
        set_upd(1'b1, 64'h80, 1'b1, 64'h300, 1'b0, 64'h0);
        step();
        reset = 1'b1;
        set_lk(1'b0, 64'h80);
        set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0); #1;
        chk("mrst_lookup_cnt", 64'(lookup_cnt), 64'd0);
        chk("mrst_branch_cnt", 64'(branch_cnt), 64'd0);
        chk("mrst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        set_lk(1'b1, 64'h80); #1;
        chk("mrst_pred_taken", 64'(pred_taken), 64'd0);
        chk("mrst_pred_target", pred_target, 64'h84);
        step();
        chk("mrst_lookup_cnt1", 64'(lookup_cnt), 64'd1);

        // 20 more valid lookups: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) step();
        chk("sat_lookup_cnt4", 64'(lookup_cnt4), 64'd15);
        chk("sat_lookup_cnt32", 64'(lookup_cnt), 64'd21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
